// File: rtl/alu_pkg.sv
// Shared opcodes, flag indices and iterative-engine state type for the ALU stage.
// Op E is MUL only when ALU_MUL_EN is defined; otherwise it is reserved.
package alu_pkg;
  localparam int WIDTH   = 8;
  localparam int SHAMT_W = 3;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_ADC  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_SBC  = 4'h3;
  localparam logic [3:0] ALU_AND  = 4'h4;
  localparam logic [3:0] ALU_OR   = 4'h5;
  localparam logic [3:0] ALU_XOR  = 4'h6;
  localparam logic [3:0] ALU_NOT  = 4'h7;
  localparam logic [3:0] ALU_SHL  = 4'h8;
  localparam logic [3:0] ALU_SHR  = 4'h9;
  localparam logic [3:0] ALU_ASR  = 4'hA;
  localparam logic [3:0] ALU_ROL  = 4'hB;
  localparam logic [3:0] ALU_ROR  = 4'hC;
  localparam logic [3:0] ALU_PASS = 4'hD;
  localparam logic [3:0] ALU_MUL  = 4'hE;
  localparam logic [3:0] ALU_RSVD = 4'hF;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {ST_IDLE = 1'b0, ST_ITER = 1'b1} iter_state_e;
endpackage

// File: rtl/alu_if.sv
// Control-sequencer / datapath bundle of the ALU stage; the slave side is the ALU.
interface alu_if;
  import alu_pkg::*;
  // i_start is taken on a rising edge only while o_busy=0 (op/operands sampled then);
  // o_done is a one-cycle pulse marking the cycle in which o_result/o_flags are new.
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [3:0]       i_op;
  logic             i_start;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic [3:0]       o_flags;
  iter_state_e      o_dbg_state;

  modport master (output i_a, i_b, i_op, i_start,
                  input  o_busy, o_done, o_result, o_flags, o_dbg_state);
  modport slave  (input  i_a, i_b, i_op, i_start,
                  output o_busy, o_done, o_result, o_flags, o_dbg_state);
endinterface

// File: rtl/alu_iter.sv
// Iterative engine: one shift/rotate step (or shift-add MUL step when ALU_MUL_EN
// is defined) per clock; fin marks the edge that completes the operation.
module alu_iter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] res,
  output logic             c_out,
  output iter_state_e      state
);
  iter_state_e      state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, step_sh;
  logic [3:0]       cnt_q, cnt_d, load_cnt;
  logic [3:0]       op_q, op_d;
  logic             last_q, last_d, step_out;
`ifdef ALU_MUL_EN
  logic [15:0]      acc_q, acc_d, acc_step, mcand_q, mcand_d;
  assign load_cnt = (op == ALU_MUL) ? 4'd8 : {1'b0, b[SHAMT_W-1:0]};
`else
  logic             unused_b_hi;
  assign unused_b_hi = ^b[WIDTH-1:SHAMT_W];
  assign load_cnt    = {1'b0, b[SHAMT_W-1:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)         state_d = ST_ITER;
      ST_ITER: if (cnt_q == 4'd1) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == ST_ITER);
    fin   = (state_q == ST_ITER) && (cnt_q == 4'd1);
    state = state_q;
  end

  // One step of the captured op; step_out is the bit leaving the register.
  always_comb begin
    step_sh  = sh_q;
    step_out = last_q;
    case (op_q)
      ALU_SHL: begin step_sh = {sh_q[WIDTH-2:0], 1'b0};     step_out = sh_q[WIDTH-1]; end
      ALU_SHR: begin step_sh = {1'b0, sh_q[WIDTH-1:1]};     step_out = sh_q[0];       end
      ALU_ASR: begin step_sh = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]}; step_out = sh_q[0];  end
      ALU_ROL: begin step_sh = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]}; step_out = sh_q[WIDTH-1]; end
      ALU_ROR: begin step_sh = {sh_q[0], sh_q[WIDTH-1:1]};  step_out = sh_q[0];       end
`ifdef ALU_MUL_EN
      ALU_MUL: step_sh = {1'b0, sh_q[WIDTH-1:1]};
`endif
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  assign acc_step = acc_q + (sh_q[0] ? mcand_q : 16'd0);
`endif

  always_comb begin
    res   = step_sh;
    c_out = step_out;
`ifdef ALU_MUL_EN
    if (op_q == ALU_MUL) begin
      res   = acc_step[WIDTH-1:0];
      c_out = |acc_step[15:8];
    end
`endif
  end

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    last_d = last_q;
`ifdef ALU_MUL_EN
    acc_d   = acc_q;
    mcand_d = mcand_q;
`endif
    if (start) begin
      sh_d   = a;
      cnt_d  = load_cnt;
      op_d   = op;
      last_d = 1'b0;
`ifdef ALU_MUL_EN
      acc_d   = 16'd0;
      mcand_d = {8'h00, b};
`endif
    end else if (busy) begin
      sh_d   = step_sh;
      cnt_d  = cnt_q - 4'd1;
      last_d = step_out;
`ifdef ALU_MUL_EN
      acc_d   = acc_step;
      mcand_d = {mcand_q[14:0], 1'b0};
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      op_q   <= '0;
      last_q <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q   <= '0;
      mcand_q <= '0;
`endif
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      last_q <= last_d;
`ifdef ALU_MUL_EN
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
`endif
    end
  end
endmodule

// File: rtl/alu_stage.sv
// ALU stage: single-cycle arithmetic/logic ops, result/flags registers and done pulse;
// shifts (and MUL when ALU_MUL_EN is defined) run in alu_iter.
module alu_stage
  import alu_pkg::*;
(
  input  logic i_clk,
  input  logic i_nReset,
  alu_if.slave bus
);
  logic             accept, is_shift, is_mul, iter_go, single_go;
  logic             iter_busy, iter_fin, iter_c;
  logic [WIDTH-1:0] iter_res;
  logic [WIDTH-1:0] result_q, result_d, sc_res;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic             sc_c, sc_v, sc_keep;
  logic [WIDTH:0]   sum9;

  assign accept   = bus.i_start && !iter_busy;
  assign is_shift = (bus.i_op >= ALU_SHL) && (bus.i_op <= ALU_ROR);
`ifdef ALU_MUL_EN
  assign is_mul   = (bus.i_op == ALU_MUL);
`else
  assign is_mul   = 1'b0;
`endif
  // A zero shift count completes like a single-cycle op and never enters ITER.
  assign iter_go   = accept && (is_mul || (is_shift && (bus.i_b[SHAMT_W-1:0] != '0)));
  assign single_go = accept && !iter_go;

  alu_iter u_iter (
    .clk   (i_clk),
    .rst_n (i_nReset),
    .start (iter_go),
    .op    (bus.i_op),
    .a     (bus.i_a),
    .b     (bus.i_b),
    .busy  (iter_busy),
    .fin   (iter_fin),
    .res   (iter_res),
    .c_out (iter_c),
    .state (bus.o_dbg_state)
  );

  always_comb begin
    sum9    = '0;
    sc_res  = bus.i_a;
    sc_c    = flags_q[FLAG_C];
    sc_v    = 1'b0;
    sc_keep = 1'b0;
    case (bus.i_op)
      ALU_ADD, ALU_ADC: begin
        sum9   = {1'b0, bus.i_a} + {1'b0, bus.i_b}
               + {8'h00, (bus.i_op == ALU_ADC) && flags_q[FLAG_C]};
        sc_res = sum9[WIDTH-1:0];
        sc_c   = sum9[WIDTH];
        sc_v   = (bus.i_a[7] == bus.i_b[7]) && (sum9[7] != bus.i_a[7]);
      end
      ALU_SUB, ALU_SBC: begin
        sum9   = {1'b0, bus.i_a} - {1'b0, bus.i_b}
               - {8'h00, (bus.i_op == ALU_SBC) && flags_q[FLAG_C]};
        sc_res = sum9[WIDTH-1:0];
        sc_c   = sum9[WIDTH];
        sc_v   = (bus.i_a[7] != bus.i_b[7]) && (sum9[7] != bus.i_a[7]);
      end
      ALU_AND:  sc_res = bus.i_a & bus.i_b;
      ALU_OR:   sc_res = bus.i_a | bus.i_b;
      ALU_XOR:  sc_res = bus.i_a ^ bus.i_b;
      ALU_NOT:  sc_res = ~bus.i_a;
      ALU_PASS: sc_res = bus.i_b;
      ALU_SHL, ALU_SHR, ALU_ASR, ALU_ROL, ALU_ROR: sc_res = bus.i_a;
      default:  sc_keep = 1'b1;
    endcase
  end

  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    if (iter_fin) begin
      result_d        = iter_res;
      flags_d[FLAG_V] = 1'b0;
      flags_d[FLAG_N] = iter_res[WIDTH-1];
      flags_d[FLAG_Z] = (iter_res == '0);
      flags_d[FLAG_C] = iter_c;
      done_d          = 1'b1;
    end else if (single_go) begin
      result_d = sc_res;
      done_d   = 1'b1;
      if (!sc_keep) begin
        flags_d[FLAG_V] = sc_v;
        flags_d[FLAG_N] = sc_res[WIDTH-1];
        flags_d[FLAG_Z] = (sc_res == '0);
        flags_d[FLAG_C] = sc_c;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_busy   = iter_busy;
  assign bus.o_done   = done_q;
  assign bus.o_result = result_q;
  assign bus.o_flags  = flags_q;
endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: vector table for single-cycle ops, hand sequences
// for shift timing, start-while-busy, mid-op reset and (with ALU_MUL_EN) MUL.
module tb_alu_stage;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  alu_if bus();

  alu_stage dut (
    .i_clk    (clk),
    .i_nReset (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge (cycle t+1).
  task automatic start_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic run_until_done(input int start_at, input logic [7:0] hold,
                                output int done_at, output int busy_cnt, output int hold_err);
    done_at  = start_at;
    busy_cnt = 0;
    hold_err = 0;
    while (bus.o_done !== 1'b1 && done_at < 40) begin
      if (bus.o_busy === 1'b1) begin
        busy_cnt++;
        if (bus.o_result !== hold) hold_err++;
      end
      @(posedge clk); #1;
      done_at++;
    end
  endtask

  task automatic iter_seq(input string name, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] hold, input int exp_done,
                          input logic [7:0] exp_res, input logic [3:0] exp_flg);
    int done_at, busy_cnt, hold_err;
    start_op(op, a, b);
    run_until_done(1, hold, done_at, busy_cnt, hold_err);
    check({name, " done_at"}, 16'(done_at), 16'(exp_done));
    check({name, " busy_cycles"}, 16'(busy_cnt), 16'(exp_done - 1));
    check({name, " hold"}, 16'(hold_err), 16'd0);
    check({name, " result"}, {8'h00, bus.o_result}, {8'h00, exp_res});
    check({name, " flags"}, {12'h000, bus.o_flags}, {12'h000, exp_flg});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at, busy_cnt, hold_err, seen_done;

    // flags nibble is {V,N,Z,C}; C carries from one row to the next
    vecs.push_back('{ALU_ADD,  8'h7F, 8'h01, 8'h80, 4'hC});
    vecs.push_back('{ALU_SUB,  8'h00, 8'h01, 8'hFF, 4'h5});
    vecs.push_back('{ALU_SBC,  8'h05, 8'h02, 8'h02, 4'h0});
    vecs.push_back('{ALU_ADD,  8'hFF, 8'h01, 8'h00, 4'h3});
    vecs.push_back('{ALU_ADC,  8'h10, 8'h20, 8'h31, 4'h0});
    vecs.push_back('{ALU_SUB,  8'h80, 8'h01, 8'h7F, 4'h8});
    vecs.push_back('{ALU_ADD,  8'h80, 8'h80, 8'h00, 4'hB});
    vecs.push_back('{ALU_AND,  8'hF0, 8'h3C, 8'h30, 4'h1});
    vecs.push_back('{ALU_OR,   8'h00, 8'h00, 8'h00, 4'h3});
    vecs.push_back('{ALU_XOR,  8'hAA, 8'hFF, 8'h55, 4'h1});
    vecs.push_back('{ALU_NOT,  8'h0F, 8'h77, 8'hF0, 4'h5});
    vecs.push_back('{ALU_PASS, 8'h12, 8'h00, 8'h00, 4'h3});
    vecs.push_back('{ALU_SBC,  8'h00, 8'h00, 8'hFF, 4'h5});
    vecs.push_back('{ALU_SHL,  8'h55, 8'h08, 8'h55, 4'h1});
    vecs.push_back('{ALU_RSVD, 8'hAB, 8'h01, 8'hAB, 4'h1});
`ifndef ALU_MUL_EN
    vecs.push_back('{ALU_MUL,  8'hCD, 8'h11, 8'hCD, 4'h1});
`endif
    vecs.push_back('{ALU_SUB,  8'h01, 8'h01, 8'h00, 4'h2});
    vecs.push_back('{ALU_ROL,  8'h80, 8'hF8, 8'h80, 4'h4});

    bus.i_a = '0; bus.i_b = '0; bus.i_op = '0; bus.i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", {8'h00, bus.o_result}, 16'h0000);
    check("reset flags", {12'h000, bus.o_flags}, 16'h0000);
    check("reset busy", {15'h0, bus.o_busy}, 16'h0000);
    check("reset done", {15'h0, bus.o_done}, 16'h0000);
    check("reset state", {15'h0, bus.o_dbg_state}, {15'h0, ST_IDLE});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // back-to-back: each start is raised in the previous op's done cycle
    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d done", i), {15'h0, bus.o_done}, 16'h0001);
      check($sformatf("vec%0d busy", i), {15'h0, bus.o_busy}, 16'h0000);
      check($sformatf("vec%0d result", i), {8'h00, bus.o_result}, {8'h00, vecs[i].res});
      check($sformatf("vec%0d flags", i), {12'h000, bus.o_flags}, {12'h000, vecs[i].flg});
    end
    @(posedge clk); #1;
    check("done pulse width", {15'h0, bus.o_done}, 16'h0000);

    iter_seq("shl81_n3", ALU_SHL, 8'h81, 8'h03, 8'h80, 4, 8'h08, 4'h0);
    @(posedge clk); #1;
    check("shl done pulse width", {15'h0, bus.o_done}, 16'h0000);
    iter_seq("ror01_n1", ALU_ROR, 8'h01, 8'h01, 8'h08, 2, 8'h80, 4'h5);
    iter_seq("asr80_n2", ALU_ASR, 8'h80, 8'h02, 8'h80, 3, 8'hE0, 4'h4);
    iter_seq("rol81_n4", ALU_ROL, 8'h81, 8'hF4, 8'hE0, 5, 8'h18, 4'h0);

    start_op(ALU_SHR, 8'hFF, 8'h07);
    check("shr busy_after_start", {15'h0, bus.o_busy}, 16'h0001);
    check("shr state_iter", {15'h0, bus.o_dbg_state}, {15'h0, ST_ITER});
    start_op(ALU_ADD, 8'h00, 8'h00);
    run_until_done(2, 8'h18, done_at, busy_cnt, hold_err);
    check("shr_ign done_at", 16'(done_at), 16'd8);
    check("shr_ign busy_cycles", 16'(busy_cnt), 16'd6);
    check("shr_ign hold", 16'(hold_err), 16'd0);
    check("shr_ign result", {8'h00, bus.o_result}, 16'h0001);
    check("shr_ign flags", {12'h000, bus.o_flags}, 16'h0001);
    @(posedge clk); #1;
    check("shr_ign no_extra_done", {15'h0, bus.o_done}, 16'h0000);
    check("shr_ign no_extra_busy", {15'h0, bus.o_busy}, 16'h0000);

`ifdef ALU_MUL_EN
    iter_seq("mul10x11", ALU_MUL, 8'h10, 8'h11, 8'h01, 9, 8'h10, 4'h1);
`endif

    start_op(ALU_SHR, 8'hF0, 8'h05);
    @(posedge clk); #1;
    check("rst_mid busy_before", {15'h0, bus.o_busy}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("rst_mid busy", {15'h0, bus.o_busy}, 16'h0000);
    check("rst_mid result", {8'h00, bus.o_result}, 16'h0000);
    check("rst_mid flags", {12'h000, bus.o_flags}, 16'h0000);
    check("rst_mid done", {15'h0, bus.o_done}, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) seen_done++;
    end
    check("rst_mid no_done_after", 16'(seen_done), 16'd0);
    check("rst_mid result_after", {8'h00, bus.o_result}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_stage.md
Name: alu_stage

Overview:
- Arithmetic/logic stage directly downstream of the register set.
- Operand A comes from the register set's ALU-select output; operand B comes from the data bus.
- Results are held in a result register that feeds the register set's write-data input. A 4-bit flags register feeds the control unit.
- Single-cycle ops plus iterative shift/rotate ops, with a start/busy/done handshake to the control sequencer.

Parameters:
- WIDTH, 8, datapath width. Only 8 is supported; the shift-count field is 3 bits.

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_nReset  input  1  reset, asynchronous, active-low.
- i_a  input  8  operand A (register set ALU output).
- i_b  input  8  operand B (bus). b[2:0] is the shift amount for shift ops.
- i_op  input  4  opcode, sampled with i_start.
- i_start  input  1  start request; accepted only when o_busy=0.
- o_busy  output  1  iterative op in progress.
- o_done  output  1  one-cycle pulse; o_result/o_flags updated at this point.
- o_result  output  8  result register (to register set write data).
- o_flags  output  4  {V,N,Z,C} = bits [3:0] as {3,2,1,0}.

Behaviour:
- Reset (async assert, sync release): o_result=0x00, o_flags=0, o_busy=0, o_done=0, iteration counter=0. Asserting reset mid-operation aborts the op and discards its result.
- Opcodes:
  - 0 ADD, 1 ADC (A+B+C), 2 SUB (A-B), 3 SBC (A-B-C).
  - 4 AND, 5 OR, 6 XOR, 7 NOT A, D PASS B.
  - 8 SHL, 9 SHR (logical), A ASR, B ROL, C ROR.
  - E reserved (see optional feature), F reserved.
- Single-cycle ops (0-7, D): start accepted at edge t loads o_result and o_flags at that edge. o_done=1 during cycle t+1; o_busy stays 0.
- Shift ops, with n=b[2:0] captured at edge t:
  - Edge t: load internal shift register with A and counter with n.
  - If n=0: same timing as a single-cycle op; result=A, C unchanged.
  - If n>0: o_busy=1 during cycles t+1..t+n. One bit shifts per edge, counter decrements, and the last bit shifted out is tracked.
  - At edge t+n, the final value loads into o_result/o_flags. o_busy=0 and o_done=1 during cycle t+n+1.
  - o_result holds its previous value while busy.
- States: IDLE -> (shift, n>0) ITER -> (counter reaches 1 at edge) IDLE with done. o_done is a registered pulse, never more than 1 cycle.
- i_start while o_busy=1: ignored; operands and op are not re-sampled.
- i_start in the o_done cycle: accepted, so back-to-back ops are allowed.
- Flags:
  - Z = (result==0) and N = result[7] for all non-reserved ops.
  - ADD/ADC: C = carry out of bit 7; V = signed overflow.
  - SUB/SBC: C = 1 on borrow; V = signed overflow.
  - Logic ops and PASS: C unchanged, V=0.
  - Shifts/rotates: C = last bit shifted out (unchanged if n=0); V=0.
  - ROL/ROR rotate through 8 bits only, not through C.
- Reserved opcodes: o_result=A, flags unchanged, o_done pulse as for a single-cycle op.
- Arithmetic is 9-bit internally for carry. Results wrap modulo 256.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: op E = MUL, an iterative shift-add over 8 bits using the ITER state.
  - o_busy=1 for exactly 8 cycles; o_done in cycle t+9.
  - o_result = low byte of A*B; C = (high byte != 0); Z/N from the low byte; V=0.
- Not defined: op E behaves as reserved (result=A, flags unchanged, single cycle); no multiplier logic is synthesised.

Decomposition:
- Package alu_pkg:
  - opcode localparams (ALU_ADD..ALU_MUL);
  - flag bit indices FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3;
  - shift-amount width SHAMT_W=3.
- Sub-module alu_iter: iterative engine holding the shift register, counter and ITER state, used for shifts and MUL. alu_stage contains the combinational single-cycle ops, the result/flags registers and the done logic.

Test Plan:
- ADD A=0x7F, B=0x01 -> o_done at t+1; result=0x80; flags V=1,N=1,Z=0,C=0.
- SUB A=0x00, B=0x01 then SBC A=0x05, B=0x02 with C=1 -> results 0xFF (C=1,N=1), then 0x02 (C=0).
- SHL A=0x81, b[2:0]=3 -> o_busy for 3 cycles, done at t+4, result=0x08, C=0. ROR A=0x01 n=1 -> result=0x80, C=1.
- Shift with n=0, A=0x55, C preset to 1 -> done at t+1, result=0x55, C stays 1. Start pulsed while busy during SHR n=7 -> ignored; result=A>>7.
- Reset asserted mid-SHR n=5 (cycle t+2) -> immediately o_busy=0, o_result=0x00, o_flags=0; no o_done after release.
- ALU_MUL_EN: A=0x10, B=0x11 -> busy 8 cycles, result=0x10, C=1. Without macro: op E -> result=A, flags unchanged, done at t+1.
